// File: rtl/exmem_if.sv
// rtl/exmem_if.sv - core bus, image load stream and byte output stream of exmem
interface exmem_if #(
  parameter int WIDTH = 32
);
  logic             memread;
  logic             memwrite;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] memdata;
  logic             cpu_reset;
  logic             ld_valid;
  logic [WIDTH-1:0] ld_data;
  logic             ld_done;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_ready;

  modport master (
    output memread, memwrite, adr, writedata, ld_valid, ld_data, ld_done, out_ready,
    input  memdata, cpu_reset, out_valid, out_data
  );

  modport slave (
    input  memread, memwrite, adr, writedata, ld_valid, ld_data, ld_done, out_ready,
    output memdata, cpu_reset, out_valid, out_data
  );
endinterface

// File: rtl/exmem.sv
// rtl/exmem.sv - word memory with image load port, core bus and optional byte output FIFO
// Define EXMEM_OUTFIFO_EN to build the memory-mapped output FIFO and its status register.
module exmem #(
  parameter int WIDTH     = 32,
  parameter int ADRBITS   = 8,
  parameter int FIFODEPTH = 4
) (
  input  logic   clk,
  input  logic   reset,
  exmem_if.slave bus
);
  typedef enum logic {LOAD, RUN} state_t;

  state_t             state;
  logic [ADRBITS-1:0] ptr;
  logic               cpu_reset_q;
  logic [WIDTH-1:0]   ram [0:(1<<ADRBITS)-1];
  logic [WIDTH-1:0]   rdata;
  logic [ADRBITS-1:0] widx;
  logic               ram_hit;
  logic               run;
  logic               unused_bits;

  assign widx    = bus.adr[ADRBITS+1:2];
  assign ram_hit = (bus.adr[WIDTH-1:ADRBITS+2] == '0);
  assign run     = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD;
      ptr         <= '0;
      cpu_reset_q <= 1'b1;
    end else begin
      case (state)
        LOAD: begin
          if (bus.ld_valid) ptr <= ptr + ADRBITS'(1);
          if (bus.ld_done) begin
            state       <= RUN;
            cpu_reset_q <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // RAM is intentionally not reset so an image survives a mid-run reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == LOAD) begin
        if (bus.ld_valid) ram[ptr] <= bus.ld_data;
      end else if (bus.memwrite && ram_hit) begin
        ram[widx] <= bus.writedata;
      end
    end
  end

`ifdef EXMEM_OUTFIFO_EN
  localparam int AW = $clog2(FIFODEPTH);
  localparam logic [WIDTH-3:0] STAT_W = ~((WIDTH-2)'(1));

  logic [7:0]       fifo [0:FIFODEPTH-1];
  logic [AW-1:0]    rdp, wrp, rdp_nx;
  logic [AW:0]      count, count_nx;
  logic             overflow;
  logic             out_valid_q;
  logic [7:0]       out_data_q, head_nx;
  logic             out_hit, stat_hit, push, pop, full, push_ok;
  logic [WIDTH-1:0] stat_word;

  assign out_hit  = &bus.adr[WIDTH-1:2];
  assign stat_hit = (bus.adr[WIDTH-1:2] == STAT_W);
  assign push     = run && bus.memwrite && out_hit;
  assign pop      = out_valid_q && bus.out_ready;
  assign full     = (count == (AW+1)'(FIFODEPTH));
  assign push_ok  = push && (!full || pop);

  always_comb begin
    count_nx = count;
    if (push_ok && !pop)      count_nx = count + (AW+1)'(1);
    else if (!push_ok && pop) count_nx = count - (AW+1)'(1);
    rdp_nx = pop ? rdp + AW'(1) : rdp;
    // The byte being pushed becomes the head when it lands where the read pointer goes next.
    head_nx = (push_ok && (wrp == rdp_nx)) ? bus.writedata[7:0] : fifo[rdp_nx];
    stat_word = '0;
    stat_word[WIDTH-1] = overflow;
    stat_word[AW:0]    = count;
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo[wrp] <= bus.writedata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdp         <= '0;
      wrp         <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (push_ok) wrp <= wrp + AW'(1);
      rdp   <= rdp_nx;
      count <= count_nx;
      if (push && full && !pop) overflow <= 1'b1;
      out_valid_q <= (count_nx != '0);
      out_data_q  <= (count_nx != '0) ? head_nx : 8'h00;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign unused_bits   = &{1'b0, bus.adr[1:0]};
`else
  assign bus.out_valid = 1'b0;
  assign bus.out_data  = 8'h00;
  assign unused_bits   = &{1'b0, bus.adr[1:0], bus.out_ready};
`endif

  always_comb begin
    rdata = '0;
    if (run && bus.memread) begin
      if (ram_hit) rdata = ram[widx];
`ifdef EXMEM_OUTFIFO_EN
      else if (stat_hit) rdata = stat_word;
`endif
    end
  end

  assign bus.memdata   = rdata;
  assign bus.cpu_reset = cpu_reset_q;
endmodule

// File: tb/tb_exmem.sv
// tb/tb_exmem.sv - directed self-checking bench for exmem
module tb_exmem;
  localparam int WIDTH = 32;
  localparam logic [31:0] OUT_A  = 32'hFFFF_FFFC;
  localparam logic [31:0] STAT_A = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  exmem_if #(.WIDTH(WIDTH)) bus();

  exmem #(.WIDTH(WIDTH), .ADRBITS(8), .FIFODEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic idle;
    bus.memread   = 1'b0;
    bus.memwrite  = 1'b0;
    bus.adr       = '0;
    bus.writedata = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    bus.ld_done   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    idle;
    bus.memread = 1'b1;
    bus.adr     = a;
    #1 check(tag, bus.memdata, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    idle;
    bus.memwrite  = 1'b1;
    bus.adr       = a;
    bus.writedata = d;
  endtask

  initial begin
    reset = 1'b1;
    bus.out_ready = 1'b0;
    idle;
    repeat (2) @(negedge clk);
    bus.memread = 1'b1;
    #1;
    check("rst_cpu_reset", bus.cpu_reset, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_memdata", bus.memdata, 0);

    // image load; the last word rides with ld_done
    @(negedge clk);
    reset = 1'b0;
    idle;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'h2002_0005;
    @(negedge clk);
    bus.ld_data  = 32'h2003_000C;
    @(negedge clk);
    bus.ld_data  = 32'h0000_0000;
    bus.ld_done  = 1'b1;
    bus.memread  = 1'b1;
    bus.adr      = 32'h4;
    #1;
    check("load_cpu_reset_at_done", bus.cpu_reset, 1);
    check("load_memdata_zero", bus.memdata, 0);
    @(negedge clk);
    idle;
    #1 check("run_cpu_reset_low", bus.cpu_reset, 0);

    rd("rd_w0", 32'h0, 32'h2002_0005);
    rd("rd_w1", 32'h4, 32'h2003_000C);
    rd("rd_w2", 32'h8, 32'h0000_0000);
    rd("rd_lowbits_ignored", 32'h5, 32'h2003_000C);
    @(negedge clk);
    idle;
    bus.adr = 32'h4;
    #1 check("rd_memread_low", bus.memdata, 0);

    wr(32'h10, 32'hDEAD_BEEF);
    rd("rd_after_store", 32'h10, 32'hDEAD_BEEF);

    @(negedge clk);
    idle;
    bus.memread   = 1'b1;
    bus.memwrite  = 1'b1;
    bus.adr       = 32'h0;
    bus.writedata = 32'h1111_1111;
    #1 check("rw_returns_old", bus.memdata, 32'h2002_0005);
    rd("rw_new_value", 32'h0, 32'h1111_1111);

    wr(32'h400, 32'hCAFE_F00D);
    rd("unmapped_keeps_w0", 32'h0, 32'h1111_1111);
    rd("unmapped_keeps_w4", 32'h10, 32'hDEAD_BEEF);
    rd("unmapped_read_zero", 32'h400, 32'h0);

`ifdef EXMEM_OUTFIFO_EN
    for (int i = 0; i < 5; i++) wr(OUT_A, 32'h1234_5600 | (32'h41 + i));
    rd("stat_overflow_count", STAT_A, 32'h8000_0004);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle;
      bus.out_ready = 1'b1;
      #1;
      check("drain1_valid", bus.out_valid, 1);
      check("drain1_data", bus.out_data, 32'h41 + i);
    end
    @(negedge clk);
    idle;
    #1 check("drain1_empty", bus.out_valid, 0);

    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(OUT_A, 32'h61 + i);
    @(negedge clk);
    idle;
    bus.memwrite  = 1'b1;
    bus.adr       = OUT_A;
    bus.writedata = 32'h5A;
    bus.out_ready = 1'b1;
    #1 check("full_head_before_pop", bus.out_data, 32'h61);
    @(negedge clk);
    idle;
    bus.out_ready = 1'b0;
    bus.memread   = 1'b1;
    bus.adr       = STAT_A;
    #1 check("full_pushpop_stat", bus.memdata, 32'h8000_0004);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle;
      bus.out_ready = 1'b1;
      #1 check("drain2_data", bus.out_data, (i == 3) ? 32'h5A : 32'h62 + i);
    end
    @(negedge clk);
    idle;
    #1 check("drain2_empty", bus.out_valid, 0);

    @(negedge clk);
    idle;
    bus.memwrite  = 1'b1;
    bus.adr       = OUT_A;
    bus.writedata = 32'h51;
    #1 check("empty_push_valid_low", bus.out_valid, 0);
    @(negedge clk);
    idle;
    #1;
    check("empty_push_valid_rise", bus.out_valid, 1);
    check("empty_push_data", bus.out_data, 32'h51);
    @(negedge clk);
    #1 check("empty_push_popped", bus.out_valid, 0);

    bus.out_ready = 1'b0;
    wr(OUT_A, 32'h52);
    @(negedge clk);
    idle;
    #1 check("midrun_pending", bus.out_valid, 1);
`else
    wr(OUT_A, 32'h41);
    @(negedge clk);
    idle;
    #1;
    check("nofifo_valid", bus.out_valid, 0);
    check("nofifo_data", bus.out_data, 0);
    rd("nofifo_stat", STAT_A, 32'h0);
    @(negedge clk);
    idle;
`endif

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrun_cpu_reset", bus.cpu_reset, 1);
    check("midrun_fifo_empty", bus.out_valid, 0);
    check("midrun_out_data", bus.out_data, 0);

    @(negedge clk);
    idle;
    bus.ld_done = 1'b1;
    bus.memread = 1'b1;
    bus.adr     = 32'h10;
    #1 check("reload_memdata_zero", bus.memdata, 0);
    @(negedge clk);
    idle;
    #1 check("reload_cpu_reset_low", bus.cpu_reset, 0);
    rd("retained_w4", 32'h10, 32'hDEAD_BEEF);
    rd("retained_w0", 32'h0, 32'h1111_1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
